// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT parameters, loader state encoding and bit-reversal helper
package fft_pkg;
    localparam int N_DEF   = 16;
    localparam int MSB_DEF = 16;

    typedef enum logic [1:0] {IDLE, FILL, LAUNCH, HOLD} loader_state_t;

    function automatic int unsigned bitrev(input int unsigned k, input int width);
        int unsigned r;
        r = 0;
        for (int i = 0; i < width; i++) r[i] = k[width-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_input_loader.sv
// fft_input_loader: serial-to-parallel bit-reversed frame loader for the FFT stage
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int MSB = MSB_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid,
    input  logic [MSB-1:0]         sample_in,
    output logic                   sample_ready,
    input  logic                   frame_ack,
    output logic                   start,
    output logic [N-1:0][MSB-1:0]  data_out,
    output logic [$clog2(N)-1:0]   wr_addr
);
    localparam int AW = $clog2(N);

    loader_state_t state, state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] slot;
    logic          xfer;

    assign slot         = AW'(bitrev(32'(cnt), AW));
    assign sample_ready = state == FILL;
    assign start        = state == LAUNCH;
    assign wr_addr      = slot;
    assign xfer         = sample_valid && sample_ready;

    // next state: fill until the last slot is written, launch, then wait for the ack
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = FILL;
            FILL:    state_nx = (xfer && cnt == AW'(N-1)) ? LAUNCH : FILL;
            LAUNCH:  state_nx = frame_ack ? FILL : HOLD;
            HOLD:    state_nx = frame_ack ? FILL : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // accepted samples land at the bit-reversed slot; count wraps at the frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            data_out <= '0;
        end else if (xfer) begin
            data_out[slot] <= sample_in;
            cnt            <= cnt + AW'(1);
        end
    end
endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Serial-to-parallel bit-reversal loader sitting directly upstream of the FFT butterfly stage. Accepts one complex sample per handshake, writes it into an N-entry frame register at the bit-reversed index, then presents the full frame on a packed bus and pulses `start` for one cycle to launch the stage. Holds the frame stable until the consumer acknowledges, then accepts the next frame.

## Interface
- `N`, 16: frame length in complex samples; power of two, ≥4.
- `MSB`, 16: sample word width; `[MSB-1:MSB/2]` = real, `[MSB/2-1:0]` = imag, two's complement.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  upstream has a sample on `sample_in`.
- `sample_in`  in  MSB  packed complex sample.
- `sample_ready`  out  1  loader accepts this cycle; transfer when `sample_valid && sample_ready`.
- `frame_ack`  in  1  stage has consumed `data_out`; frame may be overwritten.
- `start`  out  1  one-cycle launch pulse to the stage.
- `data_out`  out  [N-1:0][MSB-1:0]  frame register, bit-reversed order.
- `wr_addr`  out  $clog2(N)  slot that the next accepted sample will be written to.

## Operation
- States: IDLE, FILL, LAUNCH, HOLD. Reset state IDLE.
- IDLE → FILL unconditionally on next edge.
- FILL: `sample_ready`=1. On transfer, `data_out[bitrev(cnt)] <= sample_in`, `cnt <= cnt+1`. Transfer with `cnt==N-1` → LAUNCH, `cnt` wraps to 0. No transfer → hold; gaps in `sample_valid` allowed.
- LAUNCH: `start`=1 for exactly this cycle, `sample_ready`=0. If `frame_ack`=1 → FILL, else → HOLD.
- HOLD: `sample_ready`=0, `data_out` frozen. `frame_ack`=1 → FILL.
- `frame_ack` ignored in IDLE and FILL.
- `bitrev(k)` reverses the low $clog2(N) bits of k. Sample k lands in slot bitrev(k); `wr_addr` = bitrev(cnt).
- Slots not written retain prior frame contents (never occurs for complete frames).
- No arithmetic on samples; stored bit-exact.

## Timing
- Reset (async assert): state IDLE, `cnt`=0, `data_out` all zeros, `start`=0, `sample_ready`=0, `wr_addr`=0.
- First `sample_ready`=1 one cycle after first edge following `rst_n` release (IDLE cycle).
- `sample_ready`, `start`, `wr_addr` are decoded from registered state/count only; no combinational path from `sample_valid` or `frame_ack` to any output.
- Write latency: sample accepted at edge t visible on `data_out` after edge t.
- Last sample accepted at edge t → `start`=1 in cycle after t; `data_out` complete and stable in that same cycle.
- Max throughput: N samples back-to-back, then ≥1 non-accepting cycle (LAUNCH); with `frame_ack` tied high, frame period = N+1 cycles.
- Reset mid-frame or mid-HOLD: partial frame discarded, all outputs to reset values immediately.

## Structure
- Package `fft_pkg`: `N`/`MSB` defaults, state enum `loader_state_t`, function `bitrev(k, width)`; shared with downstream stage and output unloader.
- Single module, no sub-module; bit reversal is a package function, not an instance.

## Test plan
- N=16, samples k=0..15 with value {k, ~k} back-to-back, `frame_ack`=1 → `start` one cycle after 16th transfer; `data_out[8]`=sample 1, `data_out[12]`=sample 3, `data_out[15]`=sample 15, `data_out[0]`=sample 0.
- Random `sample_valid` gaps (50%) over 3 frames → every frame identical to gap-free reference; exactly one `start` pulse per frame; `wr_addr` sequence 0,8,4,12,2,…
- `frame_ack` held low 20 cycles after launch → `sample_ready`=0 and `data_out` unchanged throughout; `frame_ack` pulse → `sample_ready`=1 next cycle.
- `frame_ack` asserted during LAUNCH cycle → HOLD skipped; FILL next cycle; `frame_ack` pulses during FILL have no effect.
- `rst_n` low after 7 transfers → all outputs zero asynchronously; after release, next 16 samples form a clean frame with no residue of the 7.
- N=8, MSB=16 build → sample 1 in slot 4, sample 3 in slot 6, `start` after 8th transfer.
